out_port_ctrl: RTL and testbench

- Per-output-port controller directly downstream of the fixed-priority switch arbiter.
- Latches the arbiter's one-hot grant and holds the crossbar selection until the packet's tail flit has passed.
- Forwards flits from the selected input to the output link under credit-based flow control.
- Drives busy back to request generation so further requests to this port are masked while a packet is in flight.

---
 rtl/out_port_ctrl.sv | 127 ++++++++++++
 tb/tb_out_port_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_ctrl.sv
// Output-port controller: holds the arbiter's grant for a whole packet and forwards
// flits from the granted input to the output link under credit-based flow control.
module out_port_ctrl #(
    parameter int NPORT   = 5,
    parameter int FLIT_W  = 64,
    parameter int CREDITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NPORT-1:0]              grt,
    input  logic [NPORT-1:0]              in_valid,
    input  logic [NPORT-1:0]              in_tail,
    input  logic [NPORT*FLIT_W-1:0]       in_flit,
    input  logic                          credit_in,
    output logic [NPORT-1:0]              in_pop,
    output logic                          out_valid,
    output logic [FLIT_W-1:0]             out_flit,
    output logic                          busy,
    output logic [NPORT-1:0]              sel,
    output logic [$clog2(CREDITS+1)-1:0]  credit_cnt,
    output logic                          err
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [NPORT-1:0]  r_sel;
    logic [NPORT-1:0]  w_nextSel;
    logic              r_outValid;
    logic [FLIT_W-1:0] r_outFlit;
    logic [CW-1:0]     r_creditCnt;
    logic              r_err;

    logic              w_selValid;
    logic              w_selTail;
    logic [FLIT_W-1:0] w_selFlit;
    logic              w_xfer;
    logic              w_grtMulti;
    logic              w_grtOneHot;
    logic              w_creditOverflow;

    // r_sel is one-hot or zero, so OR-ing the masked inputs acts as the crossbar mux
    always_comb begin
        w_selFlit = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (r_sel[i]) begin
                w_selFlit = w_selFlit | in_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    assign w_selValid       = |(in_valid & r_sel);
    assign w_selTail        = |(in_tail & r_sel);
    assign w_xfer           = !rst && (r_state == ACTIVE) && w_selValid && (r_creditCnt != '0);
    assign w_grtMulti       = (grt & (grt - NPORT'(1))) != '0;
    assign w_grtOneHot      = (grt != '0) && !w_grtMulti;
    assign w_creditOverflow = credit_in && !w_xfer && (r_creditCnt == CREDIT_MAX);

    always_comb begin
        w_nextState = r_state;
        w_nextSel   = r_sel;
        case (r_state)
            IDLE: begin
                if (w_grtOneHot) begin
                    w_nextState = ACTIVE;
                    w_nextSel   = grt;
                end
            end
            ACTIVE: begin
                if (w_xfer && w_selTail) begin
                    w_nextState = IDLE;
                    w_nextSel   = '0;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextSel   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_nextState;
            r_sel   <= w_nextSel;
        end
    end

    // A simultaneous transfer and credit return cancel out; a return at full count is an error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_outFlit   <= '0;
            r_creditCnt <= CREDIT_MAX;
            r_err       <= 1'b0;
        end else begin
            r_outValid <= w_xfer;
            if (w_xfer) begin
                r_outFlit <= w_selFlit;
            end
            if (w_xfer && !credit_in) begin
                r_creditCnt <= r_creditCnt - CW'(1);
            end else if (credit_in && !w_xfer && (r_creditCnt != CREDIT_MAX)) begin
                r_creditCnt <= r_creditCnt + CW'(1);
            end
            r_err <= w_creditOverflow || ((r_state == IDLE) && w_grtMulti);
        end
    end

    assign in_pop     = {NPORT{w_xfer}} & r_sel;
    assign out_valid  = r_outValid;
    assign out_flit   = r_outFlit;
    assign busy       = (r_state == ACTIVE);
    assign sel        = r_sel;
    assign credit_cnt = r_creditCnt;
    assign err        = r_err;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Bench for out_port_ctrl: a cycle model predicts control outputs, and a flit
// scoreboard checks that every packet flit reaches the output link in order.
module tb_out_port_ctrl;
    localparam int NPORT   = 5;
    localparam int FLIT_W  = 64;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NPORT-1:0]        grt;
    logic [NPORT-1:0]        inValid;
    logic [NPORT-1:0]        inTail;
    logic [NPORT*FLIT_W-1:0] inFlit;
    logic                    creditIn;
    logic [NPORT-1:0]        inPop;
    logic                    outValid;
    logic [FLIT_W-1:0]       outFlit;
    logic                    busy;
    logic [NPORT-1:0]        sel;
    logic [CW-1:0]           creditCnt;
    logic                    err;

    always #5 clk = ~clk;

    out_port_ctrl #(.NPORT(NPORT), .FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst), .grt(grt), .in_valid(inValid), .in_tail(inTail),
        .in_flit(inFlit), .credit_in(creditIn), .in_pop(inPop), .out_valid(outValid),
        .out_flit(outFlit), .busy(busy), .sel(sel), .credit_cnt(creditCnt), .err(err)
    );

    int errors = 0;
    int checks = 0;

    logic [FLIT_W-1:0] srcQ[$];
    logic [FLIT_W-1:0] expQ[$];
    int                srcPort;

    logic              mActive;
    logic [NPORT-1:0]  mSel;
    int                mCredit;
    logic              mErr;
    logic              mOutValid;
    logic [FLIT_W-1:0] mOutFlit;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic loadPacket(input int port, input int len);
        logic [FLIT_W-1:0] f;
        srcPort = port;
        for (int i = 0; i < len; i++) begin
            f = {$urandom, $urandom};
            srcQ.push_back(f);
            expQ.push_back(f);
        end
    endtask

    // One clock: drive at negedge, check in_pop, clock the model, check registered outputs
    task automatic applyStimulus(input logic [NPORT-1:0] g, input logic cin, input logic r);
        int               s;
        logic             xfer;
        logic             tail;
        logic [NPORT-1:0] expPop;
        grt      = g;
        creditIn = cin;
        rst      = r;
        inValid  = NPORT'($urandom);
        inTail   = NPORT'($urandom);
        for (int i = 0; i < NPORT; i++) begin
            inFlit[i*FLIT_W +: FLIT_W] = {$urandom, $urandom};
        end
        inValid[srcPort] = (srcQ.size() > 0);
        inTail[srcPort]  = (srcQ.size() == 1);
        if (srcQ.size() > 0) begin
            inFlit[srcPort*FLIT_W +: FLIT_W] = srcQ[0];
        end
        s = 0;
        for (int i = 0; i < NPORT; i++) begin
            if (mSel[i]) s = i;
        end
        xfer   = !r && mActive && inValid[s] && (mCredit != 0);
        tail   = inTail[s];
        expPop = xfer ? mSel : '0;
        #1;
        checkOutput("in_pop", 64'(inPop), 64'(expPop));
        @(posedge clk);
        if (r) begin
            mActive = 1'b0; mSel = '0; mCredit = CREDITS; mErr = 1'b0;
            mOutValid = 1'b0; mOutFlit = '0;
            srcQ.delete();
            expQ.delete();
        end else begin
            mErr = 1'b0;
            if (cin && !xfer && mCredit == CREDITS) mErr = 1'b1;
            else if (xfer && !cin) mCredit--;
            else if (cin && !xfer) mCredit++;
            if (xfer) begin
                mOutFlit = inFlit[s*FLIT_W +: FLIT_W];
                if (s == srcPort && srcQ.size() > 0) void'(srcQ.pop_front());
            end
            mOutValid = xfer;
            if (!mActive) begin
                if (g != '0) begin
                    if ($countones(g) == 1) begin
                        mActive = 1'b1;
                        mSel    = g;
                    end else begin
                        mErr = 1'b1;
                    end
                end
            end else if (xfer && tail) begin
                mActive = 1'b0;
                mSel    = '0;
            end
        end
        @(negedge clk);
        checkOutput("busy", 64'(busy), 64'(mActive));
        checkOutput("sel", 64'(sel), 64'(mSel));
        checkOutput("credit_cnt", 64'(creditCnt), 64'(mCredit));
        checkOutput("err", 64'(err), 64'(mErr));
        checkOutput("out_valid", 64'(outValid), 64'(mOutValid));
        checkOutput("out_flit", outFlit, mOutFlit);
        if (outValid === 1'b1) begin
            if (expQ.size() == 0) checkOutput("sb_underflow", 64'(expQ.size()), 64'd1);
            else checkOutput("sb_flit", outFlit, expQ.pop_front());
        end
    endtask

    task automatic runUntilIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!mActive && srcQ.size() == 0) break;
            applyStimulus('0, 1'b0, 1'b0);
        end
        checkOutput("pkt_done", 64'(busy), 64'd0);
    endtask

    task automatic refillCredits();
        for (int i = 0; i < CREDITS && mCredit < CREDITS; i++) begin
            applyStimulus('0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; grt = '0; creditIn = 1'b0; inValid = '0; inTail = '0; inFlit = '0;
        srcPort = 0;
        mActive = 1'b0; mSel = '0; mCredit = CREDITS; mErr = 1'b0;
        mOutValid = 1'b0; mOutFlit = '0;
        @(negedge clk);
        applyStimulus('0, 1'b0, 1'b1);
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("rst_credit", 64'(creditCnt), 64'(CREDITS));
        checkOutput("rst_busy", 64'(busy), 64'd0);

        // single-flit packet from input 2
        loadPacket(2, 1);
        applyStimulus(5'b00100, 1'b0, 1'b0);
        checkOutput("t1_sel", 64'(sel), 64'b00100);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("t1_credit", 64'(creditCnt), 64'd3);
        checkOutput("t1_idle", 64'(busy), 64'd0);
        refillCredits();

        // four-flit packet from input 4 drains all credits
        loadPacket(4, 4);
        applyStimulus(5'b10000, 1'b0, 1'b0);
        runUntilIdle(10);
        checkOutput("t2_credit", 64'(creditCnt), 64'd0);
        refillCredits();

        // six-flit packet stalls on credits, resumes after each return
        loadPacket(1, 6);
        applyStimulus(5'b00010, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus('0, 1'b0, 1'b0);
        checkOutput("t3_stalled", 64'(srcQ.size()), 64'd2);
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        runUntilIdle(5);
        refillCredits();

        // credit return coinciding with a transfer, then overflow while idle
        loadPacket(0, 3);
        applyStimulus(5'b00001, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("t4_at2", 64'(creditCnt), 64'd2);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t4_hold2", 64'(creditCnt), 64'd2);
        refillCredits();
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t4_sat", 64'(creditCnt), 64'(CREDITS));
        checkOutput("t4_err", 64'(err), 64'd1);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("t4_err_pulse", 64'(err), 64'd0);

        // grants ignored while active; multi-hot grant while idle
        loadPacket(3, 4);
        applyStimulus(5'b01000, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus(5'b00001, 1'b0, 1'b0);
        checkOutput("t5_sel_held", 64'(sel), 64'b01000);
        runUntilIdle(6);
        refillCredits();
        applyStimulus(5'b00011, 1'b0, 1'b0);
        checkOutput("t5_multi_err", 64'(err), 64'd1);
        checkOutput("t5_multi_idle", 64'(busy), 64'd0);

        // reset after two of four flits aborts the packet
        loadPacket(3, 4);
        applyStimulus(5'b01000, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_sel", 64'(sel), 64'd0);
        checkOutput("t6_valid", 64'(outValid), 64'd0);
        checkOutput("t6_credit", 64'(creditCnt), 64'(CREDITS));
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("sb_drain", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
